instr_fetch: RTL and testbench

Instruction fetch stage for the PhilosophyV core. It sits directly upstream of `instr_decoder`. It owns the program counter and issues word requests to instruction memory. Returned words are buffered in a small in-order queue and presented to the decoder with a valid/ready handshake. Branch/jump redirects flush the queue and silently discard responses already in flight.

---
 rtl/instr_fetch.sv | 198 +++++++++++++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PhilosophyV instruction fetch stage, directly upstream of
// instr_decoder. Owns the program counter, issues word requests to
// instruction memory, buffers returned words in an in-order queue and hands
// them to the decoder over a valid/ready handshake. A redirect flushes the
// queue and marks every response still in flight for silent discard.
//
// Build option: define FETCH_BYPASS_EN to let a response go straight to the
// decoder when the queue is empty (0-cycle response-to-output latency).
// Without it every word passes through the queue and the output ports are
// driven from registers only.
module instr_fetch #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int unsigned  QDEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [CW:0]  QD_LIM = (CW + 1)'(QDEPTH);
  localparam logic [N-1:0] NOP    = N'(32'h0000_0013);
  localparam logic [N-1:0] PC_RST = {RESET_PC[N-1:2], 2'b00};

  // Fetch queue: instruction word and its address, written at wr_ptr.
  logic [N-1:0]  q_instr [QDEPTH];
  logic [N-1:0]  q_pc    [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Address of every granted request, consumed in order by the responses.
  logic [N-1:0]  rpc_mem [QDEPTH];
  logic [AW-1:0] rpc_wr;
  logic [AW-1:0] rpc_rd;

  logic [N-1:0]  pc;
  logic [N-1:0]  last_pc;
  logic [CW-1:0] pend;
  logic [CW-1:0] kill;
  logic          req_en;

  logic [CW:0]   occupancy;
  logic          grant;
  logic          rsp_ok;
  logic          rsp_drop;
  logic          rsp_keep;
  logic [CW-1:0] pend_dec;
  logic          q_push;
  logic          q_pop;
  logic [N-1:0]  rsp_pc;
  logic          bypass_take;
  logic          unused_bits;

  // Low address bits of the redirect target are discarded by design.
  assign unused_bits = ^redirect_pc[1:0];

  // Requests are capped so every granted word is guaranteed a queue slot.
  assign occupancy = {1'b0, count} + {1'b0, pend};
  assign imem_req  = req_en && !redirect && (occupancy < QD_LIM);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // A response with nothing pending is a protocol error and is ignored.
  assign rsp_ok   = imem_rvalid && (pend != '0);
  assign rsp_drop = rsp_ok && (kill != '0);
  assign rsp_keep = rsp_ok && (kill == '0);
  assign pend_dec = rsp_ok ? (pend - CW'(1)) : pend;
  assign rsp_pc   = rpc_mem[rpc_rd];

  assign q_pop  = (count != '0) && out_ready;
  assign q_push = rsp_keep && !redirect && !bypass_take;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;

  // The word skips the queue only when nothing older is waiting ahead of it.
  assign bypass_hit  = rsp_keep && !redirect && (count == '0);
  assign bypass_take = bypass_hit && out_ready;
`else
  assign bypass_take = 1'b0;
`endif

  // Control state: pc, queue pointers/count, pending and kill counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= PC_RST;
      last_pc <= PC_RST;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rpc_wr  <= '0;
      rpc_rd  <= '0;
      pend    <= '0;
      kill    <= '0;
      req_en  <= 1'b0;
    end else begin
      req_en <= 1'b1;

      if (out_valid) begin
        last_pc <= out_pc;
      end

      // The address FIFO tracks every granted request, killed or not, so it
      // stays aligned with the in-order response stream across redirects.
      if (grant) begin
        rpc_wr <= rpc_wr + AW'(1);
      end
      if (rsp_ok) begin
        rpc_rd <= rpc_rd + AW'(1);
      end

      if (grant && !rsp_ok) begin
        pend <= pend + CW'(1);
      end else if (!grant && rsp_ok) begin
        pend <= pend - CW'(1);
      end

      if (redirect) begin
        pc     <= {redirect_pc[N-1:2], 2'b00};
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        // Everything still outstanding after this cycle belongs to the old
        // path; already-killed responses are a subset of pend, not extra.
        kill   <= pend_dec;
      end else begin
        if (grant) begin
          pc <= pc + N'(4);
        end
        if (rsp_drop) begin
          kill <= kill - CW'(1);
        end
        if (q_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (q_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({q_push, q_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= rsp_pc;
    end
    if (grant) begin
      rpc_mem[rpc_wr] <= pc;
    end
  end

  // Decoder-facing outputs: queue head, or NOP with the last pc held.
  always_comb begin
    out_valid = 1'b0;
    out_instr = NOP;
    out_pc    = last_pc;
    if (count != '0) begin
      out_valid = 1'b1;
      out_instr = q_instr[rd_ptr];
      out_pc    = q_pc[rd_ptr];
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass_hit) begin
      out_valid = 1'b1;
      out_instr = imem_rdata;
      out_pc    = rsp_pc;
    end
`endif
  end

`ifndef SYNTHESIS
  a_rvalid_needs_pend: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (pend != '0)
  ) else $error("instr_fetch: imem_rvalid with no pending request");
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch. A memory model grants and answers
// requests with random latency; a reference model tags each request with the
// redirect epoch it was issued in and expects only same-epoch words, in order.
// Expected words go into a queue that a separate monitor pops and compares.
module tb_instr_fetch;

  localparam int          QD     = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_fetch #(.N(32), .RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];

  int          tests;
  int          fails;
  int          cyc;
  int          epoch;
  int          grant_cnt;
  logic [31:0] exp_pc;
  logic [31:0] last_pc;
  int          p_redir;
  int          p_gnt;
  int          p_ready;
  int          lat_min;
  int          lat_max;
  bit          force_redir;
  logic [31:0] force_pc;
  bit          first_armed;
  bit          first_seen;
  logic [31:0] first_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_mode(input int redir, input int gnt, input int rdy, input int lmin, input int lmax);
    p_redir = redir;
    p_gnt   = gnt;
    p_ready = rdy;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  // One clock: drive at the falling edge, check requests, then advance the model.
  task automatic run_cycle();
    mreq_t r;
    bit    rd;
    bit    granted;
    @(negedge clk);
    cyc++;
    rd          = force_redir || ($urandom_range(99) < p_redir);
    redirect    = rd;
    redirect_pc = force_redir ? force_pc : $urandom();
    force_redir = 1'b0;
    out_ready   = ($urandom_range(99) < p_ready);
    imem_gnt    = ($urandom_range(99) < p_gnt);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
    #1;
    chk("imem_req", 32'(imem_req), 32'(!rd && (exp_q.size() + mem_q.size() < QD)));
    chk("imem_addr", imem_addr, exp_pc);
    granted = imem_req && imem_gnt;
    #2;
    if (imem_rvalid) begin
      r = mem_q.pop_front();
      if (!rd && r.epoch == epoch) exp_q.push_back('{r.data, r.addr});
    end
    if (granted) begin
      grant_cnt++;
      mem_q.push_back('{exp_pc, $urandom(), epoch, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) begin
      exp_q.delete();
      epoch++;
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    out_ready   = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc", out_pc, RST_PC);
    exp_q.delete();
    mem_q.delete();
    exp_pc  = RST_PC;
    last_pc = RST_PC;
    epoch++;
    // A stale response arriving while reset is held must leave no trace.
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    rst_n       = 1'b1;
    #1;
    chk("release_req", 32'(imem_req), 32'd0);
    chk("release_valid", 32'(out_valid), 32'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the expected queue.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_instr", out_instr, exp_q[0].instr);
        chk("out_pc", out_pc, exp_q[0].pc);
        last_pc = exp_q[0].pc;
        if (first_armed && !first_seen) begin
          first_seen = 1'b1;
          first_pc   = out_pc;
        end
        if (out_ready) void'(exp_q.pop_front());
      end else if (!out_valid) begin
        chk("idle_instr", out_instr, NOP);
        chk("idle_pc", out_pc, last_pc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    epoch       = 0;
    grant_cnt   = 0;
    exp_pc      = RST_PC;
    last_pc     = RST_PC;
    force_redir = 1'b0;
    force_pc    = '0;
    first_armed = 1'b0;
    first_seen  = 1'b0;
    first_pc    = '0;
    redirect_pc = '0;
    imem_rdata  = '0;
    set_mode(0, 100, 100, 1, 1);

    // Streaming from reset with 1-cycle memory and an always-ready decoder.
    do_reset();
    repeat (20) run_cycle();

    // Decoder stalled: exactly QD grants, then requests stop.
    do_reset();
    set_mode(0, 100, 0, 1, 3);
    grant_cnt = 0;
    repeat (12) run_cycle();
    chk("stall_grants", 32'(grant_cnt), 32'(QD));
    chk("stall_out_pc", out_pc, RST_PC);
    p_ready = 100;
    repeat (10) run_cycle();

    // Redirect to 0x103 with two slow requests outstanding.
    do_reset();
    set_mode(0, 100, 100, 6, 6);
    repeat (2) run_cycle();
    force_redir = 1'b1;
    force_pc    = 32'h0000_0103;
    run_cycle();
    first_armed = 1'b1;
    first_seen  = 1'b0;
    repeat (20) run_cycle();
    chk("redir_seen", 32'(first_seen), 32'd1);
    chk("redir_first_pc", first_pc, 32'h0000_0100);
    first_armed = 1'b0;

    // Address wrap at the top of the address space.
    set_mode(0, 100, 100, 1, 2);
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFFE;
    run_cycle();
    first_armed = 1'b1;
    first_seen  = 1'b0;
    repeat (12) run_cycle();
    chk("wrap_seen", 32'(first_seen), 32'd1);
    chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);
    first_armed = 1'b0;

    // Random traffic with redirects, stalls and variable latency.
    set_mode(6, 70, 70, 1, 4);
    repeat (3000) run_cycle();

    // Reset in the middle of traffic with requests outstanding.
    set_mode(0, 100, 50, 3, 5);
    repeat (3) run_cycle();
    do_reset();

    set_mode(10, 80, 60, 1, 3);
    repeat (2000) run_cycle();

    // Drain: no new grants; everything expected must come out.
    set_mode(0, 0, 100, 1, 4);
    repeat (30) run_cycle();
    chk("drain_expected", 32'(exp_q.size()), 32'd0);
    chk("drain_outstanding", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
